brick_map_ctrl: RTL and testbench

BRICK_MAP_CTRL -- requirements
Module: brick_map_ctrl

---
 rtl/brick_pkg.sv | 40 ++++
 rtl/brick_addr_decode.sv | 33 +++
 rtl/brick_map_ctrl.sv | 159 +++++++++++++++
 tb/tb_brick_map_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared definitions for the brick map controller.
// Holds the brick field geometry, the controller state encoding and the
// {row,col} brick index type. No ports.
package brick_pkg;

  // Brick field geometry in pixels
  localparam int unsigned GRID_X0   = 64;
  localparam int unsigned GRID_Y0   = 64;
  localparam int unsigned GRID_COLS = 16;
  localparam int unsigned GRID_ROWS = 8;
  localparam int unsigned BRICK_W   = 32;
  localparam int unsigned BRICK_H   = 16;
  localparam int unsigned FIELD_W   = GRID_COLS * BRICK_W;
  localparam int unsigned FIELD_H   = GRID_ROWS * BRICK_H;

  // Datapath widths
  localparam int unsigned PIX_X_W   = 10;
  localparam int unsigned PIX_Y_W   = 9;
  localparam int unsigned ROW_W     = 3;
  localparam int unsigned COL_W     = 4;
  localparam int unsigned IDX_W     = ROW_W + COL_W;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned SCORE_W   = 12;

  localparam int unsigned NUM_BRICKS = GRID_COLS * GRID_ROWS;
  localparam int unsigned SCORE_MAX  = (1 << SCORE_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_REFILL = 2'd2
  } brick_state_e;

  // 7-bit brick index, row in the upper bits
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } brick_idx_t;

endpackage

// File: rtl/brick_addr_decode.sv
// Combinational pixel-to-brick decode.
// Ports:
//   pix_x, pix_y  : current render pixel
//   in_field_c    : pixel lies inside the brick field
//   row_c, col_c  : brick row/column covering the pixel (valid when in_field_c)
module brick_addr_decode
  import brick_pkg::*;
(
  input  logic [PIX_X_W-1:0] pix_x,
  input  logic [PIX_Y_W-1:0] pix_y,
  output logic               in_field_c,
  output logic [ROW_W-1:0]   row_c,
  output logic [COL_W-1:0]   col_c
);

  logic [PIX_X_W-1:0] dx;
  logic [PIX_Y_W-1:0] dy;

  always_comb begin
    dx = pix_x - PIX_X_W'(GRID_X0);
    dy = pix_y - PIX_Y_W'(GRID_Y0);

    in_field_c = (pix_x >= PIX_X_W'(GRID_X0)) &&
                 (pix_x <  PIX_X_W'(GRID_X0 + FIELD_W)) &&
                 (pix_y >= PIX_Y_W'(GRID_Y0)) &&
                 (pix_y <  PIX_Y_W'(GRID_Y0 + FIELD_H));

    // Brick dimensions are powers of two, so the offset shifts down to an index
    col_c = COL_W'(dx >> $clog2(BRICK_W));
    row_c = ROW_W'(dy >> $clog2(BRICK_H));
  end

endmodule

// File: rtl/brick_map_ctrl.sv
// Brick field storage and hit/refill controller.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   frame_pulse       : end-of-frame strobe; hits and refills are applied here
//   pix_x, pix_y      : render pixel being looked up
//   block_collision   : ball overlaps the brick reported on brick_present
//   reset_game        : refill field and clear score at next frame_pulse
//   brick_present     : live brick covers the pixel from the previous cycle
//   brick_row         : row of that brick
//   bricks_left       : live brick count
//   score             : bricks destroyed since last game reset (saturating)
//   level_clear       : one-cycle pulse when the last brick goes
//   busy              : controller is in CLEAR or REFILL
module brick_map_ctrl
  import brick_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_pulse,
  input  logic [PIX_X_W-1:0] pix_x,
  input  logic [PIX_Y_W-1:0] pix_y,
  input  logic               block_collision,
  input  logic               reset_game,
  output logic               brick_present,
  output logic [ROW_W-1:0]   brick_row,
  output logic [CNT_W-1:0]   bricks_left,
  output logic [SCORE_W-1:0] score,
  output logic               level_clear,
  output logic               busy
);

  logic               in_field_c;
  logic [ROW_W-1:0]   row_c;
  logic [COL_W-1:0]   col_c;

  brick_state_e                         state_q,         state_d;
  logic [GRID_ROWS-1:0][GRID_COLS-1:0]  map_q,           map_d;
  brick_idx_t                           idx_q,           idx_d;
  brick_idx_t                           hit_q,           hit_d;
  logic                                 hit_pending_q,   hit_pending_d;
  logic [ROW_W-1:0]                     refill_row_q,    refill_row_d;
  logic                                 brick_present_q, brick_present_d;
  logic [ROW_W-1:0]                     brick_row_q,     brick_row_d;
  logic [CNT_W-1:0]                     bricks_left_q,   bricks_left_d;
  logic [SCORE_W-1:0]                   score_q,         score_d;
  logic                                 level_clear_q,   level_clear_d;
  logic                                 busy_q,          busy_d;

  brick_addr_decode u_decode (
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .in_field_c (in_field_c),
    .row_c      (row_c),
    .col_c      (col_c)
  );

  // Next-state, storage update and output computation
  always_comb begin
    state_d         = state_q;
    map_d           = map_q;
    hit_d           = hit_q;
    hit_pending_d   = hit_pending_q;
    refill_row_d    = refill_row_q;
    bricks_left_d   = bricks_left_q;
    score_d         = score_q;
    level_clear_d   = 1'b0;

    // Lookup is pipelined one cycle; index travels with it to line up with block_collision
    brick_present_d = in_field_c && map_q[row_c][col_c] && (state_q != ST_REFILL);
    brick_row_d     = in_field_c ? row_c : '0;
    idx_d.row       = row_c;
    idx_d.col       = col_c;

    case (state_q)
      ST_IDLE: begin
        if (frame_pulse && reset_game) begin
          // Game reset wins over any pending hit
          state_d       = ST_REFILL;
          score_d       = '0;
          hit_pending_d = 1'b0;
          refill_row_d  = '0;
        end else if (frame_pulse && hit_pending_q) begin
          state_d = ST_CLEAR;
        end else if (block_collision && brick_present_q && !hit_pending_q) begin
          // Only the first hit of a frame is kept
          hit_d         = idx_q;
          hit_pending_d = 1'b1;
        end
      end

      ST_CLEAR: begin
        map_d[hit_q.row][hit_q.col] = 1'b0;
        bricks_left_d = bricks_left_q - CNT_W'(1);
        score_d       = (score_q == SCORE_W'(SCORE_MAX)) ? score_q : score_q + SCORE_W'(1);
        hit_pending_d = 1'b0;
        if (bricks_left_q == CNT_W'(1)) begin
          state_d       = ST_REFILL;
          level_clear_d = 1'b1;
          refill_row_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REFILL: begin
        map_d[refill_row_q] = '1;
        refill_row_d        = refill_row_q + ROW_W'(1);
        if (refill_row_q == ROW_W'(GRID_ROWS - 1)) begin
          bricks_left_d = CNT_W'(NUM_BRICKS);
          state_d       = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // busy is registered from the next state so it tracks state_q exactly
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      map_q           <= '1;
      idx_q           <= '0;
      hit_q           <= '0;
      hit_pending_q   <= 1'b0;
      refill_row_q    <= '0;
      brick_present_q <= 1'b0;
      brick_row_q     <= '0;
      bricks_left_q   <= CNT_W'(NUM_BRICKS);
      score_q         <= '0;
      level_clear_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      map_q           <= map_d;
      idx_q           <= idx_d;
      hit_q           <= hit_d;
      hit_pending_q   <= hit_pending_d;
      refill_row_q    <= refill_row_d;
      brick_present_q <= brick_present_d;
      brick_row_q     <= brick_row_d;
      bricks_left_q   <= bricks_left_d;
      score_q         <= score_d;
      level_clear_q   <= level_clear_d;
      busy_q          <= busy_d;
    end
  end

  assign brick_present = brick_present_q;
  assign brick_row     = brick_row_q;
  assign bricks_left   = bricks_left_q;
  assign score         = score_q;
  assign level_clear   = level_clear_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_brick_map_ctrl.sv
// Directed self-checking bench for brick_map_ctrl.
module tb_brick_map_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_pulse;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        block_collision;
  logic        reset_game;
  logic        brick_present;
  logic [2:0]  brick_row;
  logic [7:0]  bricks_left;
  logic [11:0] score;
  logic        level_clear;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  brick_map_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .frame_pulse     (frame_pulse),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .block_collision (block_collision),
    .reset_game      (reset_game),
    .brick_present   (brick_present),
    .brick_row       (brick_row),
    .bricks_left     (bricks_left),
    .score           (score),
    .level_clear     (level_clear),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 9'(y);
  endtask

  // Point the pixel a few px inside brick (r,c)
  task automatic set_brick(input int r, input int c);
    set_pix(64 + c * 32 + 5, 64 + r * 16 + 5);
  endtask

  // Look up brick (r,c) and assert block_collision aligned with the registered lookup
  task automatic collide(input int r, input int c);
    set_brick(r, c);
    tick();
    block_collision = 1'b1;
    tick();
    block_collision = 1'b0;
  endtask

  task automatic frame();
    frame_pulse = 1'b1;
    tick();
    frame_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_pulse = 1'b0; block_collision = 1'b0; reset_game = 1'b0;
    pix_x = '0; pix_y = '0;
    do_reset();

    // Reset state
    chk("rst_present", int'(brick_present), 0);
    chk("rst_row",     int'(brick_row), 0);
    chk("rst_left",    int'(bricks_left), 128);
    chk("rst_score",   int'(score), 0);
    chk("rst_lclear",  int'(level_clear), 0);
    chk("rst_busy",    int'(busy), 0);

    // Field boundaries
    set_pix(64, 64);   tick(); chk("px64_64", int'(brick_present), 1); chk("px64_64_row", int'(brick_row), 0);
    set_pix(63, 64);   tick(); chk("px63_64", int'(brick_present), 0);
    set_pix(576, 64);  tick(); chk("px576_64", int'(brick_present), 0);
    set_pix(575, 191); tick(); chk("px575_191", int'(brick_present), 1); chk("px575_191_row", int'(brick_row), 7);
    set_pix(64, 192);  tick(); chk("px64_192", int'(brick_present), 0);
    set_pix(64, 63);   tick(); chk("px64_63", int'(brick_present), 0);
    set_pix(100, 100); tick(); chk("px100_100_row", int'(brick_row), 2);

    // Single hit at (100,80): row1/col1
    set_pix(100, 80); tick(); block_collision = 1'b1; tick(); block_collision = 1'b0;
    frame();
    chk("hit_busy_clear", int'(busy), 1);
    tick();
    chk("hit_busy_idle", int'(busy), 0);
    chk("hit_left", int'(bricks_left), 127);
    chk("hit_score", int'(score), 1);
    tick();
    chk("hit_px_gone", int'(brick_present), 0);

    // Two collisions in one frame: only the first clears
    do_reset();
    collide(2, 2);
    collide(3, 3);
    frame();
    tick();
    chk("dbl_left", int'(bricks_left), 127);
    chk("dbl_score", int'(score), 1);
    set_brick(2, 2); tick(); chk("dbl_first_gone", int'(brick_present), 0);
    set_brick(3, 3); tick(); chk("dbl_second_live", int'(brick_present), 1);

    // Clear down to one brick, then the last hit triggers a level refill
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        if (!((r == 2 && c == 2) || (r == 7 && c == 15))) begin
          collide(r, c);
          frame();
          tick();
        end
      end
    end
    chk("lvl_left_one", int'(bricks_left), 1);
    chk("lvl_score_127", int'(score), 127);
    collide(7, 15);
    frame();
    chk("lvl_busy_clear", int'(busy), 1);
    chk("lvl_no_early_pulse", int'(level_clear), 0);
    tick();
    chk("lvl_pulse", int'(level_clear), 1);
    chk("lvl_busy_r1", int'(busy), 1);
    chk("lvl_left_zero", int'(bricks_left), 0);
    set_brick(0, 0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("lvl_busy_r%0d", i), int'(busy), 1);
      chk($sformatf("lvl_pulse_off_r%0d", i), int'(level_clear), 0);
      chk($sformatf("lvl_masked_r%0d", i), int'(brick_present), 0);
    end
    tick();
    chk("lvl_busy_done", int'(busy), 0);
    chk("lvl_left_full", int'(bricks_left), 128);
    chk("lvl_score_kept", int'(score), 128);
    tick();
    chk("lvl_refilled", int'(brick_present), 1);

    // Pending hit and reset_game at the same frame_pulse
    collide(0, 0);
    reset_game = 1'b1;
    frame_pulse = 1'b1;
    tick();
    reset_game = 1'b0;
    frame_pulse = 1'b0;
    chk("rg_busy", int'(busy), 1);
    chk("rg_score", int'(score), 0);
    chk("rg_left_r1", int'(bricks_left), 128);
    repeat (7) tick();
    chk("rg_busy_r8", int'(busy), 1);
    tick();
    chk("rg_busy_done", int'(busy), 0);
    chk("rg_left", int'(bricks_left), 128);
    chk("rg_score_done", int'(score), 0);
    set_brick(0, 0); tick(); chk("rg_not_cleared", int'(brick_present), 1);

    // rst during the 4th REFILL cycle
    collide(6, 3);
    frame();
    tick();
    chk("ab_left_pre", int'(bricks_left), 127);
    chk("ab_score_pre", int'(score), 1);
    reset_game = 1'b1;
    frame_pulse = 1'b1;
    tick();
    reset_game = 1'b0;
    frame_pulse = 1'b0;
    repeat (3) tick();
    chk("ab_busy_r4", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_score", int'(score), 0);
    chk("ab_left", int'(bricks_left), 128);
    chk("ab_lclear", int'(level_clear), 0);
    chk("ab_present", int'(brick_present), 0);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        set_brick(r, c);
        tick();
        chk($sformatf("ab_live_r%0d_c%0d", r, c), int'(brick_present), 1);
      end
    end
    chk("ab_row_last", int'(brick_row), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
